// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger lane block: tile codes, row map,
// per-lane reload values, reset patterns and small row/tile helpers.
package frogger_pkg;

  typedef enum logic [3:0] {
    TILE_GRASS = 4'd0,
    TILE_ROAD  = 4'd1,
    TILE_WATER = 4'd2,
    TILE_LOG   = 4'd3,
    TILE_LILY  = 4'd4,
    TILE_CAR   = 4'd5,
    TILE_HEDGE = 4'd6
  } tile_e;

  localparam int c_GAME_WIDTH  = 14;
  localparam int c_LANE_BITS   = 14;
  localparam int c_NUM_LANES   = 12;

  localparam logic [5:0] c_ROW_HOME        = 6'd0;
  localparam logic [5:0] c_ROW_RIVER_FIRST = 6'd1;
  localparam logic [5:0] c_ROW_RIVER_LAST  = 6'd6;
  localparam logic [5:0] c_ROW_MEDIAN      = 6'd7;
  localparam logic [5:0] c_ROW_ROAD_FIRST  = 6'd8;
  localparam logic [5:0] c_ROW_ROAD_LAST   = 6'd13;
  localparam logic [5:0] c_ROW_START       = 6'd14;

  // Lane index 0-5 are river rows 1-6, lane index 6-11 are road rows 8-13.
  localparam logic [5:0] c_RELOAD [c_NUM_LANES] = '{
    6'd39, 6'd39, 6'd39, 6'd39, 6'd39, 6'd39,
    6'd20, 6'd28, 6'd16, 6'd34, 6'd24, 6'd12
  };

  localparam logic [13:0] c_RESET_PATTERN [c_NUM_LANES] = '{
    14'h0E38, 14'h3C0F, 14'h01F8, 14'h0E1C, 14'h3870, 14'h07C7,
    14'h0603, 14'h1830, 14'h0C18, 14'h2041, 14'h0306, 14'h1818
  };

  // River rows and the even road rows move left; odd road rows move right.
  function automatic bit lane_shifts_left(input int idx);
    return (idx < 6) || (((idx - 6) % 2) == 0);
  endfunction

  function automatic tile_e home_tile(input logic [5:0] x);
    tile_e t;
    case (x)
      6'd1, 6'd4, 6'd7, 6'd10, 6'd13: t = TILE_LILY;
      default:                        t = TILE_HEDGE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/frogger_lanes_lane_shifter.sv
// One moving row: a tick-driven countdown and the 14-bit occupancy
// pattern that rotates one column each time the countdown expires.
module lane_shifter
  import frogger_pkg::*;
#(
  parameter logic [5:0]  p_RELOAD        = 6'd39,
  parameter logic [13:0] p_RESET_PATTERN = 14'h0000,
  parameter bit          p_SHIFT_LEFT    = 1'b1
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Tick,
  output logic [13:0] o_Pattern
);

  logic [5:0]  count_reg;
  logic [13:0] pattern_reg;
  logic [13:0] pattern_next;

  // Left: bit c takes bit c+1, bit 13 takes bit 0. Right: the mirror image.
  always_comb begin
    if (p_SHIFT_LEFT)
      pattern_next = {pattern_reg[0], pattern_reg[13:1]};
    else
      pattern_next = {pattern_reg[12:0], pattern_reg[13]};
  end

  // The tick that takes the count to zero reloads it in the same edge,
  // so a row moves exactly once every p_RELOAD ticks.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      count_reg   <= p_RELOAD;
      pattern_reg <= p_RESET_PATTERN;
    end else if (i_Tick) begin
      if (count_reg <= 6'd1) begin
        count_reg   <= p_RELOAD;
        pattern_reg <= pattern_next;
      end else begin
        count_reg <= count_reg - 6'd1;
      end
    end
  end

  assign o_Pattern = pattern_reg;

endmodule

// File: rtl/frogger_lanes.sv
// Frogger playfield lanes: tick prescaler, twelve moving rows, and two
// registered tile lookup ports (frog position and renderer cell).
module frogger_lanes #(
  parameter int c_GAME_WIDTH  = frogger_pkg::c_GAME_WIDTH,
  parameter int c_TICK_PERIOD = 1000000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Game_Active,
  input  logic [5:0] i_Frogger_X,
  input  logic [5:0] i_Frogger_Y,
  input  logic [5:0] i_Col_Count_Div,
  input  logic [5:0] i_Row_Count_Div,
  output logic       o_Collided,
  output logic       o_On_Log,
  output logic [3:0] o_Bitmap_Data,
  output logic [3:0] o_Tile_Code
);

  import frogger_pkg::*;

  localparam int c_PRESC_W = (c_TICK_PERIOD > 1) ? $clog2(c_TICK_PERIOD) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(c_TICK_PERIOD - 1);

  logic [c_PRESC_W-1:0] presc_reg;
  logic                 tick;
  logic [13:0]          lane_pattern [c_NUM_LANES];
  tile_e                frog_tile;
  tile_e                render_tile;

  assign tick = i_Game_Active && (presc_reg == c_PRESC_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Reset)
      presc_reg <= '0;
    else if (i_Game_Active)
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
  end

  generate
    for (genvar gi = 0; gi < c_NUM_LANES; gi++) begin : g_lane
      lane_shifter #(
        .p_RELOAD       (c_RELOAD[gi]),
        .p_RESET_PATTERN(c_RESET_PATTERN[gi]),
        .p_SHIFT_LEFT   (lane_shifts_left(gi))
      ) u_lane (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Tick   (tick),
        .o_Pattern(lane_pattern[gi])
      );
    end
  endgenerate

  // Reads the current (pre-shift) pattern registers.
  function automatic tile_e tile_lookup(input logic [5:0] x, input logic [5:0] y);
    tile_e      t;
    logic [3:0] ly;
    t  = TILE_GRASS;
    ly = y[3:0];
    if ((int'(x) < c_GAME_WIDTH) && (int'(x) < c_LANE_BITS) && (y <= c_ROW_START)) begin
      if (y == c_ROW_HOME)
        t = home_tile(x);
      else if (y >= c_ROW_RIVER_FIRST && y <= c_ROW_RIVER_LAST)
        t = lane_pattern[ly - 4'd1][x[3:0]] ? TILE_LOG : TILE_WATER;
      else if (y >= c_ROW_ROAD_FIRST && y <= c_ROW_ROAD_LAST)
        t = lane_pattern[ly - 4'd2][x[3:0]] ? TILE_CAR : TILE_ROAD;
    end
    return t;
  endfunction

  always_comb begin
    frog_tile   = tile_lookup(i_Frogger_X, i_Frogger_Y);
    render_tile = tile_lookup(i_Col_Count_Div, i_Row_Count_Div);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Bitmap_Data <= 4'd0;
      o_On_Log      <= 1'b0;
      o_Collided    <= 1'b0;
      o_Tile_Code   <= 4'd0;
    end else begin
      o_Bitmap_Data <= frog_tile;
      o_On_Log      <= (frog_tile == TILE_LOG);
      o_Collided    <= (frog_tile == TILE_CAR);
      o_Tile_Code   <= render_tile;
    end
  end

endmodule

// File: tb/tb_frogger_lanes.sv
// Self-checking bench for frogger_lanes with a closed-form lane model and
// a scoreboard of expected outputs, one entry per driven cycle.
module tb_frogger_lanes;

  localparam int TICK = 4;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b0;
  logic       i_Game_Active = 1'b0;
  logic [5:0] i_Frogger_X = '0;
  logic [5:0] i_Frogger_Y = '0;
  logic [5:0] i_Col_Count_Div = '0;
  logic [5:0] i_Row_Count_Div = '0;
  logic       o_Collided;
  logic       o_On_Log;
  logic [3:0] o_Bitmap_Data;
  logic [3:0] o_Tile_Code;

  typedef struct packed {
    logic       col;
    logic       log;
    logic [3:0] bm;
    logic [3:0] tc;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   act_cnt = 0;

  const int INIT [12] = '{'h0E38, 'h3C0F, 'h01F8, 'h0E1C, 'h3870, 'h07C7,
                          'h0603, 'h1830, 'h0C18, 'h2041, 'h0306, 'h1818};
  const int RELOAD [12] = '{39, 39, 39, 39, 39, 39, 20, 28, 16, 34, 24, 12};

  frogger_lanes #(.c_GAME_WIDTH(14), .c_TICK_PERIOD(TICK)) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_Game_Active  (i_Game_Active),
    .i_Frogger_X    (i_Frogger_X),
    .i_Frogger_Y    (i_Frogger_Y),
    .i_Col_Count_Div(i_Col_Count_Div),
    .i_Row_Count_Div(i_Row_Count_Div),
    .o_Collided     (o_Collided),
    .o_On_Log       (o_On_Log),
    .o_Bitmap_Data  (o_Bitmap_Data),
    .o_Tile_Code    (o_Tile_Code)
  );

  always #5 i_Clk = ~i_Clk;

  // Active clocks since the last reset; lane shifts follow in closed form.
  always @(posedge i_Clk) begin
    if (i_Reset) act_cnt <= 0;
    else if (i_Game_Active) act_cnt <= act_cnt + 1;
  end

  function automatic logic [13:0] model_pattern(input int idx);
    logic [13:0] base, res;
    int          n;
    bit          left;
    base = 14'(INIT[idx]);
    left = (idx < 6) || (((idx - 6) % 2) == 0);
    n    = (act_cnt / (TICK * RELOAD[idx])) % 14;
    for (int c = 0; c < 14; c++)
      res[c] = left ? base[(c + n) % 14] : base[(c + 14 - n) % 14];
    return res;
  endfunction

  function automatic logic [3:0] model_tile(input int x, input int y);
    logic [13:0] p;
    if (x >= 14 || y > 14) return 4'd0;
    if (y == 0) return (x % 3 == 1) ? 4'd4 : 4'd6;
    if (y >= 1 && y <= 6) begin
      p = model_pattern(y - 1);
      return p[x] ? 4'd3 : 4'd2;
    end
    if (y >= 8 && y <= 13) begin
      p = model_pattern(y - 2);
      return p[x] ? 4'd5 : 4'd1;
    end
    return 4'd0;
  endfunction

  function automatic exp_t got_now();
    return {o_Collided, o_On_Log, o_Bitmap_Data, o_Tile_Code};
  endfunction

  // Drives one cycle of inputs, queues the expected registered result,
  // and returns just after the edge that produces it.
  task automatic cycle(input logic rst, input logic act, input int fx, input int fy,
                       input int cx, input int cy);
    exp_t       e;
    logic [3:0] ft;
    @(negedge i_Clk);
    i_Reset = rst;
    i_Game_Active = act;
    i_Frogger_X = 6'(fx);
    i_Frogger_Y = 6'(fy);
    i_Col_Count_Div = 6'(cx);
    i_Row_Count_Div = 6'(cy);
    ft = model_tile(fx, fy);
    if (rst) e = '0;
    else e = {ft == 4'd5, ft == 4'd3, ft, model_tile(cx, cy)};
    sb.push_back(e);
    @(posedge i_Clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, g;
    cycle(1'b1, 1'b0, 10, 14, 1, 0);
    e = sb.pop_front(); g = got_now(); checks++;
    if (g !== 10'h000) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", g, 10'h000); end
    cycle(1'b0, 1'b0, 10, 14, 1, 0);
    e = sb.pop_front(); g = got_now(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_lookup_sb got=%h exp=%h", g, e); end
    checks++;
    if (g !== exp_t'({1'b0, 1'b0, 4'd0, 4'd4})) begin
      errors++; $display("FAIL reset_lookup_const got=%h exp=%h", g, {1'b0, 1'b0, 4'd0, 4'd4});
    end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_road();
    exp_t e, g;
    cycle(1'b0, 1'b0, 0, 8, 13, 2);
    e = sb.pop_front(); g = got_now(); checks++;
    if (g !== e || o_Collided !== 1'b1 || o_Bitmap_Data !== 4'd5 || o_On_Log !== 1'b0) begin
      errors++; $display("FAIL road_car got=%h exp=%h (col=1 bm=5)", g, e);
    end
    cycle(1'b0, 1'b0, 2, 8, 0, 7);
    e = sb.pop_front(); g = got_now(); checks++;
    if (g !== e || o_Collided !== 1'b0 || o_Bitmap_Data !== 4'd1 || o_Tile_Code !== 4'd0) begin
      errors++; $display("FAIL road_empty got=%h exp=%h (col=0 bm=1 tc=0)", g, e);
    end
    $display("test_road done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_bounds();
    int   pts [10][2] = '{'{14, 3}, '{63, 0}, '{0, 15}, '{5, 63}, '{13, 0},
                          '{12, 0}, '{0, 7}, '{13, 14}, '{13, 13}, '{0, 1}};
    exp_t e, g;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, pts[i][0], pts[i][1], pts[9 - i][0], pts[9 - i][1]);
      e = sb.pop_front(); g = got_now(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL bounds (%0d,%0d) got=%h exp=%h", pts[i][0], pts[i][1], g, e);
      end
    end
    $display("test_bounds done checks=%0d errors=%0d", checks, errors);
  endtask

  // Runs n cycles from a fresh reset, optionally pausing or resetting
  // along the way, and checks the first cycle at which the frog on (2,1)
  // reads a log.
  task automatic run_log_ride(input string name, input int pause_cycles,
                              input int reset_at, input int want_edge);
    exp_t e, g;
    int   first_on = -1;
    int   edge_n = 0;
    cycle(1'b1, 1'b0, 2, 1, 13, 2);
    e = sb.pop_front();
    for (int i = 0; i < pause_cycles; i++) begin
      cycle(1'b0, 1'b0, 2, 1, 13, 2);
      e = sb.pop_front(); g = got_now(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s_pause i=%0d got=%h exp=%h", name, i, g, e); end
    end
    for (int i = 1; i <= want_edge + 3; i++) begin
      cycle(i == reset_at, 1'b1, 2, 1, 13, 2);
      edge_n = i;
      e = sb.pop_front(); g = got_now(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s edge=%0d got=%h exp=%h", name, i, g, e); end
      if (o_On_Log === 1'b1 && first_on < 0) first_on = edge_n;
    end
    checks++;
    if (first_on !== want_edge) begin
      errors++; $display("FAIL %s_first_log edge got=%0d exp=%0d", name, first_on, want_edge);
    end
    $display("%s done checks=%0d errors=%0d", name, checks, errors);
  endtask

  task automatic test_render_wrap();
    exp_t e, g;
    cycle(1'b1, 1'b0, 0, 0, 13, 2);
    e = sb.pop_front();
    for (int i = 1; i <= 160; i++) begin
      cycle(1'b0, 1'b1, 0, 0, 13, 2);
      e = sb.pop_front(); g = got_now(); checks++;
      if (g !== e) begin errors++; $display("FAIL render_wrap edge=%0d got=%h exp=%h", i, g, e); end
    end
    checks++;
    if (o_Tile_Code !== 4'd3) begin
      errors++; $display("FAIL render_wrap_final got=%0d exp=3", o_Tile_Code);
    end
    $display("test_render_wrap done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    for (int i = 0; i < 1500; i++) begin
      cycle(1'b0, ($urandom_range(0, 7) != 0), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15));
      e = sb.pop_front(); g = got_now(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b i=%0d frog=(%0d,%0d) rend=(%0d,%0d) got=%h exp=%h", i,
                 i_Frogger_X, i_Frogger_Y, i_Col_Count_Div, i_Row_Count_Div, g, e);
      end
    end
    $display("test_back_to_back done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_road();
    test_bounds();
    run_log_ride("test_log_ride", 0, -1, 157);
    run_log_ride("test_pause", 1000, -1, 157);
    run_log_ride("test_reset_mid", 0, 100, 257);
    test_render_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
